// File: rtl/ad9826_sport_slave_if.sv
// AD9826 3-wire serial configuration pins (SLOAD/SCLK/SDATA) as seen at the FPGA pads.
interface ad9826_sport_slave_if;
  logic sload;
  logic sclk;
  logic sdata_in;
  logic sdata_out;
  logic sdata_oe;

  modport master (output sload, sclk, sdata_in, input sdata_out, sdata_oe);
  modport slave  (input sload, sclk, sdata_in, output sdata_out, sdata_oe);
endinterface

// File: rtl/ad9826_sport_slave.sv
// AD9826 serial-port responder: eight 9-bit config registers behind an oversampled SLOAD/SCLK/SDATA port.
// States: WAIT_HIGH hold until SLOAD high | IDLE await frame | SHIFT collect 16 bits | DONE frame complete
module ad9826_sport_slave (
  input  logic                       clk,
  input  logic                       reset,
  ad9826_sport_slave_if.slave        sport,
  output logic [71:0]                cfg_regs,
  output logic                       wr_strobe,
  output logic [2:0]                 wr_addr,
  output logic [8:0]                 wr_data,
  output logic                       frame_err
);
  typedef enum logic [1:0] {WAIT_HIGH, IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [1:0]  sload_s;
  logic [2:0]  sclk_s;
  logic [1:0]  sdata_s;
  logic [4:0]  bit_cnt;
  logic [15:0] shreg;
  logic        rw;
  logic        commit;
  logic [8:0]  rd_shift;
  logic [8:0]  regs [8];

  logic sload_q, rise, fall, bit_in;
  assign sload_q = sload_s[1];
  assign rise    = sclk_s[1] & ~sclk_s[2];
  assign fall    = ~sclk_s[1] & sclk_s[2];
  assign bit_in  = sdata_s[1];

  always_comb begin
    cfg_regs = '0;
    for (int i = 0; i < 8; i++) cfg_regs[i*9 +: 9] = regs[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= WAIT_HIGH;
      sload_s         <= '0;
      sclk_s          <= '0;
      sdata_s         <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      rw              <= 1'b0;
      commit          <= 1'b0;
      rd_shift        <= '0;
      wr_strobe       <= 1'b0;
      wr_addr         <= '0;
      wr_data         <= '0;
      frame_err       <= 1'b0;
      sport.sdata_out <= 1'b0;
      sport.sdata_oe  <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      sload_s   <= {sload_s[0], sport.sload};
      sclk_s    <= {sclk_s[1:0], sport.sclk};
      sdata_s   <= {sdata_s[0], sport.sdata_in};
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      commit    <= 1'b0;

      // shreg is frozen in DONE, so the full frame is still intact one cycle after the last bit
      if (commit && !shreg[15]) begin
        regs[shreg[14:12]] <= shreg[8:0];
        wr_addr            <= shreg[14:12];
        wr_data            <= shreg[8:0];
        wr_strobe          <= 1'b1;
      end

      case (state)
        WAIT_HIGH: if (sload_q) state <= IDLE;
        IDLE: begin
          if (!sload_q) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            shreg   <= '0;
            rw      <= 1'b0;
          end
        end
        SHIFT: begin
          if (rise) begin
            shreg   <= {shreg[14:0], bit_in};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd0) rw <= bit_in;
            if (bit_cnt == 5'd15) begin
              state  <= DONE;
              commit <= 1'b1;
            end
          end else if (sload_q) begin
            if (bit_cnt != 5'd0) frame_err <= 1'b1;
            state <= IDLE;
          end
        end
        DONE: if (sload_q) state <= IDLE;
        default: state <= WAIT_HIGH;
      endcase

      // Read data is snapshotted on the first driving fall; shreg[5:3] holds A2..A0 at bit_cnt 7
      if (sload_q || (fall && state == DONE)) begin
        sport.sdata_oe  <= 1'b0;
        sport.sdata_out <= 1'b0;
      end else if (fall && state == SHIFT && rw && bit_cnt >= 5'd7) begin
        if (!sport.sdata_oe) begin
          rd_shift        <= regs[shreg[5:3]];
          sport.sdata_out <= regs[shreg[5:3]][8];
          sport.sdata_oe  <= 1'b1;
        end else begin
          sport.sdata_out <= rd_shift[7];
          rd_shift        <= {rd_shift[7:0], rd_shift[0]};
        end
      end
    end
  end
endmodule

// File: tb/tb_ad9826_sport_slave.sv
// Bench for ad9826_sport_slave: drives SPORT frames as a master and checks against a register-array model.
module tb_ad9826_sport_slave;
  logic        clk = 1'b0;
  logic        reset;
  logic [71:0] cfg_regs;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic [8:0]  wr_data;
  logic        frame_err;

  ad9826_sport_slave_if sport ();

  ad9826_sport_slave dut (
    .clk       (clk),
    .reset     (reset),
    .sport     (sport),
    .cfg_regs  (cfg_regs),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int strobe_cnt = 0;
  int err_cnt    = 0;
  int oe_cycles  = 0;
  int h          = 8;
  bit jit        = 1'b0;
  logic [8:0] model [8];

  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (frame_err) err_cnt++;
    if (sport.sdata_oe) oe_cycles++;
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] model_flat();
    logic [71:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[i*9 +: 9] = model[i];
    return f;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int ph();
    return jit ? h - 1 + int'($urandom_range(0, 2)) : h;
  endfunction

  task automatic frame_start();
    sport.sload = 1'b0;
    wait_clks(ph());
  endtask

  task automatic send_bit(input logic b, output logic so, output logic oe);
    sport.sdata_in = b;
    wait_clks(ph());
    so = sport.sdata_out;
    oe = sport.sdata_oe;
    sport.sclk = 1'b1;
    wait_clks(ph());
    sport.sclk = 1'b0;
  endtask

  task automatic frame_end(output logic oe_after);
    sport.sload = 1'b1;
    wait_clks(3);
    oe_after = sport.sdata_oe;
    wait_clks(1 + (jit ? int'($urandom_range(0, 1)) : 0));
  endtask

  task automatic xfer(input logic [15:0] w, output logic [8:0] rd,
                      output logic oe7, output logic oe8, output logic oe_after);
    logic so, oe;
    rd = '0; oe7 = 1'b0; oe8 = 1'b0;
    frame_start();
    for (int i = 0; i < 16; i++) begin
      send_bit(w[15-i], so, oe);
      if (i >= 7) rd[15-i] = so;
      if (i == 6) oe7 = oe;
      if (i == 7) oe8 = oe;
    end
    frame_end(oe_after);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [8:0] d);
    logic [8:0] rd;
    logic o7, o8, oa;
    int s0, oe0;
    s0  = strobe_cnt;
    oe0 = oe_cycles;
    xfer({1'b0, a, 3'($urandom), d}, rd, o7, o8, oa);
    model[a] = d;
    wait_clks(4);
    check("wr_strobe_count", 72'(strobe_cnt - s0), 72'(1));
    check("wr_addr", 72'(wr_addr), 72'(a));
    check("wr_data", 72'(wr_data), 72'(d));
    check("cfg_regs_after_write", cfg_regs, model_flat());
    check("oe_in_write_frame", 72'(oe_cycles - oe0), 72'(0));
  endtask

  task automatic do_read(input logic [2:0] a);
    logic [8:0] rd;
    logic o7, o8, oa;
    int s0;
    s0 = strobe_cnt;
    xfer({1'b1, a, 3'($urandom), 9'($urandom)}, rd, o7, o8, oa);
    check("read_data", 72'(rd), 72'(model[a]));
    check("oe_before_turnaround", 72'(o7), 72'(0));
    check("oe_at_rise8", 72'(o8), 72'(1));
    check("oe_after_sload", 72'(oa), 72'(0));
    check("no_strobe_on_read", 72'(strobe_cnt - s0), 72'(0));
  endtask

  initial begin
    logic so, oe, oa;
    logic [15:0] w;
    int s0, e0;

    for (int i = 0; i < 8; i++) model[i] = '0;
    reset = 1'b1;
    sport.sload = 1'b1;
    sport.sclk = 1'b0;
    sport.sdata_in = 1'b0;
    wait_clks(4);
    reset = 1'b0;
    wait_clks(2);
    check("reset_cfg_regs", cfg_regs, 72'(0));
    check("reset_sdata_oe", 72'(sport.sdata_oe), 72'(0));
    check("reset_sdata_out", 72'(sport.sdata_out), 72'(0));
    check("reset_wr_strobe", 72'(wr_strobe), 72'(0));
    check("reset_wr_addr", 72'(wr_addr), 72'(0));
    check("reset_wr_data", 72'(wr_data), 72'(0));
    check("reset_frame_err", 72'(frame_err), 72'(0));
    wait_clks(4);

    // write 0x30A5 then read it back with 0xB000
    do_write(3'd3, 9'h0A5);
    do_read(3'd3);

    // truncated write 0x5123 after 10 bits
    s0 = strobe_cnt; e0 = err_cnt;
    w = 16'h5123;
    frame_start();
    for (int i = 0; i < 10; i++) send_bit(w[15-i], so, oe);
    frame_end(oa);
    wait_clks(4);
    check("trunc_frame_err", 72'(err_cnt - e0), 72'(1));
    check("trunc_no_strobe", 72'(strobe_cnt - s0), 72'(0));
    check("trunc_cfg_regs", cfg_regs, model_flat());

    // reset in the middle of a write to addr 7, SLOAD held low throughout
    s0 = strobe_cnt; e0 = err_cnt;
    w = {4'h7, 3'($urandom), 9'($urandom)};
    frame_start();
    for (int i = 0; i < 8; i++) send_bit(w[15-i], so, oe);
    reset = 1'b1;
    wait_clks(2);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    for (int i = 8; i < 16; i++) send_bit(w[15-i], so, oe);
    frame_end(oa);
    wait_clks(4);
    check("midreset_cfg_regs", cfg_regs, 72'(0));
    check("midreset_no_strobe", 72'(strobe_cnt - s0), 72'(0));
    check("midreset_no_frame_err", 72'(err_cnt - e0), 72'(0));
    do_write(3'($urandom), 9'($urandom));

    // back-to-back writes to every address, then read them all
    s0 = strobe_cnt;
    for (int n = 0; n < 8; n++) do_write(3'(n), 9'(9'h100 + n));
    check("b2b_strobe_total", 72'(strobe_cnt - s0), 72'(8));
    for (int n = 0; n < 8; n++) do_read(3'(n));

    // random traffic
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 0) do_write(3'($urandom), 9'($urandom));
      else do_read(3'($urandom));
    end

    // 10 MHz SCLK with edge jitter
    h = 5;
    jit = 1'b1;
    do_write(3'd5, 9'h1FF);
    do_read(3'd5);
    for (int k = 0; k < 6; k++) begin
      do_write(3'($urandom), 9'($urandom));
      do_read(3'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
